// File: rtl/i2s_receiver.sv
// i2s_receiver: I2S slave deserialiser producing left/right sample pairs; define I2S_RX_MONO_EN to add mono_out.
module i2s_receiver #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_BITS = 16
) (
  input  logic                  serial_clk,
  input  logic                  reset,
  input  logic                  word_select,
  input  logic                  sound_bit_in,
  output logic [DATA_WIDTH-1:0] left_out,
  output logic [DATA_WIDTH-1:0] right_out,
  output logic                  sample_valid,
  output logic                  frame_error,
`ifdef I2S_RX_MONO_EN
  output logic [DATA_WIDTH-1:0] mono_out,
`endif
  output logic                  locked
);
  localparam int CW = SLOT_BITS > 1 ? $clog2(SLOT_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLOT_BITS - 1);
  typedef enum logic {SYNC_WAIT, RECEIVING} state_t;
  state_t state;
  logic ws_d, hold_valid, ws_edge, shift_en, good;
  logic [CW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg, left_hold, word;
`ifdef I2S_RX_MONO_EN
  logic [DATA_WIDTH:0] mono_sum;
  assign mono_sum = {left_hold[DATA_WIDTH-1], left_hold} + {word[DATA_WIDTH-1], word};
`endif
  always_comb begin
    ws_edge = word_select != ws_d;
    shift_en = int'(bit_cnt) < DATA_WIDTH;
    word = shift_en ? {shift_reg[DATA_WIDTH-2:0], sound_bit_in} : shift_reg;
    good = bit_cnt == LAST;
  end
  // The edge-cycle bit is the previous word's LSB, so the completed word includes it.
  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      state <= SYNC_WAIT;
      ws_d <= 1'b0;
      bit_cnt <= '0;
      shift_reg <= '0;
      left_hold <= '0;
      hold_valid <= 1'b0;
      left_out <= '0;
      right_out <= '0;
      sample_valid <= 1'b0;
      frame_error <= 1'b0;
      locked <= 1'b0;
`ifdef I2S_RX_MONO_EN
      mono_out <= '0;
`endif
    end else begin
      ws_d <= word_select;
      shift_reg <= word;
      bit_cnt <= ws_edge ? '0 : bit_cnt + 1'b1;
      sample_valid <= 1'b0;
      frame_error <= 1'b0;
      if (state == SYNC_WAIT) begin
        if (ws_edge && !word_select) begin
          state <= RECEIVING;
          locked <= 1'b1;
        end
      end else if (ws_edge) begin
        if (!good) begin
          frame_error <= 1'b1;
          hold_valid <= 1'b0;
        end else if (word_select) begin
          left_hold <= word;
          hold_valid <= 1'b1;
        end else if (hold_valid) begin
          left_out <= left_hold;
          right_out <= word;
          sample_valid <= 1'b1;
          hold_valid <= 1'b0;
`ifdef I2S_RX_MONO_EN
          mono_out <= mono_sum[DATA_WIDTH:1];
`endif
        end
      end else if (good) begin
        frame_error <= 1'b1;
        hold_valid <= 1'b0;
        state <= SYNC_WAIT;
        locked <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: slot-level reference model feeding a scoreboard of timed events for i2s_receiver.
module tb_i2s_receiver;
  localparam int DW = 16;
  localparam int SB = 16;
  localparam int K_PAIR = 0, K_ERR = 1, K_LOCK = 2, K_UNLOCK = 3;
  logic serial_clk = 0, reset = 0, word_select = 0, sound_bit_in = 0;
  logic [DW-1:0] left_out, right_out;
  logic sample_valid, frame_error, locked;
`ifdef I2S_RX_MONO_EN
  logic [DW-1:0] mono_out;
`endif
  i2s_receiver #(.DATA_WIDTH(DW), .SLOT_BITS(SB)) dut (
    .serial_clk(serial_clk),
    .reset(reset),
    .word_select(word_select),
    .sound_bit_in(sound_bit_in),
    .left_out(left_out),
    .right_out(right_out),
    .sample_valid(sample_valid),
    .frame_error(frame_error),
`ifdef I2S_RX_MONO_EN
    .mono_out(mono_out),
`endif
    .locked(locked)
  );
  always #5 serial_clk = ~serial_clk;
  typedef struct {
    int kind;
    int t;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } ev_t;
  ev_t sb[$];
  logic ws_q[$];
  logic d_q[$];
  int n_chk = 0, n_fail = 0, drv_n = 0, drv_cyc = 0, push_t = 0;
  bit m_locked = 0, m_hv = 0, m_prev_ws = 0, p_ws = 0, prev_locked = 0;
  int p_len = 0;
  logic [DW-1:0] p_word = '0, m_hold = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void expect_ev(input int kind, input int t, input logic [DW-1:0] l, input logic [DW-1:0] r);
    ev_t e;
    e.kind = kind; e.t = t; e.l = l; e.r = r;
    sb.push_back(e);
  endfunction

  function automatic logic [DW-1:0] mono_of(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int s;
    s = int'($signed(l)) + int'($signed(r));
    return DW'(s >>> 1);
  endfunction

  // One channel slot: ws held for len cycles, word MSB-first; the model judges it at the slot boundary.
  task automatic slot(input bit ws, input int len, input logic [DW-1:0] w);
    int t0 = push_t;
    for (int k = 0; k < len; k++) begin
      ws_q.push_back(ws);
      d_q.push_back(k < DW ? w[DW-1-k] : 1'b0);
    end
    if (m_locked) begin
      if (ws != m_prev_ws) begin
        if (p_len != SB) begin
          expect_ev(K_ERR, t0, '0, '0);
          m_hv = 0;
        end else if (p_ws == 0) begin
          m_hold = p_word;
          m_hv = 1;
        end else if (m_hv) begin
          expect_ev(K_PAIR, t0, m_hold, p_word);
          m_hv = 0;
        end
      end
    end else if (ws != m_prev_ws && !ws) begin
      m_locked = 1;
      expect_ev(K_LOCK, t0, '0, '0);
    end
    if (m_locked && len > SB) begin
      expect_ev(K_ERR, t0 + SB, '0, '0);
      expect_ev(K_UNLOCK, t0 + SB, '0, '0);
      m_locked = 0;
      m_hv = 0;
    end
    p_ws = ws; p_len = len; p_word = w; m_prev_ws = ws;
    push_t += len;
  endtask

  task automatic drain(input int extra);
    int n = 0;
    while (ws_q.size() != 0 && n < 20000) begin
      @(negedge serial_clk);
      n++;
    end
    if (ws_q.size() != 0) chk("drain_timeout", ws_q.size(), 0);
    repeat (extra) @(negedge serial_clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_left"}, left_out, 0);
    chk({tag, "_right"}, right_out, 0);
    chk({tag, "_valid"}, sample_valid, 0);
    chk({tag, "_error"}, frame_error, 0);
    chk({tag, "_locked"}, locked, 0);
`ifdef I2S_RX_MONO_EN
    chk({tag, "_mono"}, mono_out, 0);
`endif
  endtask

  initial forever begin
    @(negedge serial_clk);
    if (ws_q.size() != 0) begin
      word_select = ws_q.pop_front();
      sound_bit_in = d_q.pop_front();
      drv_cyc = drv_n;
      drv_n++;
    end
  end

  task automatic got(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d expected none at cycle %0d", kind, drv_cyc);
      return;
    end
    e = sb.pop_front();
    chk("event_kind", kind, e.kind);
    chk("event_cycle", drv_cyc, e.t);
    if (kind == K_PAIR) begin
      chk("left_out", left_out, e.l);
      chk("right_out", right_out, e.r);
`ifdef I2S_RX_MONO_EN
      chk("mono_out", mono_out, mono_of(e.l, e.r));
`endif
    end
  endtask

  always @(posedge serial_clk) begin
    #1;
    if (reset) begin
      if (sample_valid || frame_error) chk("valid_error_exclusive", sample_valid & frame_error, 0);
      if (sample_valid) got(K_PAIR);
      if (frame_error) got(K_ERR);
      if (locked != prev_locked) got(locked ? K_LOCK : K_UNLOCK);
      prev_locked = locked;
    end else prev_locked = 0;
  end

  initial begin
    logic [DW-1:0] pairs [6][2];
    bit ws;
    pairs = '{'{16'h0001, 16'h8000}, '{16'hFFFF, 16'h0000}, '{16'h7FFF, 16'h8001},
              '{16'h7FFF, 16'h7FFF}, '{16'h8000, 16'h7FFF}, '{16'h0004, 16'h0002}};
    d_q.push_back(1'b0);
    repeat (3) @(negedge serial_clk);
    check_zero("reset");
    reset = 1;
    slot(0, 16, 16'h0000);
    slot(1, 16, 16'hFFFF);
    slot(0, 16, 16'hA5C3);
    slot(1, 16, 16'h1234);
    for (int i = 0; i < 6; i++) begin
      slot(0, 16, pairs[i][0]);
      slot(1, 16, pairs[i][1]);
    end
    slot(0, 10, 16'h3333);
    slot(1, 16, 16'h4444);
    slot(0, 16, 16'h1111);
    slot(1, 16, 16'h2222);
    slot(0, 20, 16'h5555);
    slot(1, 16, 16'h0000);
    slot(0, 16, 16'h6666);
    slot(1, 16, 16'h7777);
    ws = 1;
    for (int i = 0; i < 40; i++) begin
      ws = ~ws;
      slot(ws, ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 20)) : SB, DW'($urandom));
    end
    slot(~ws, 40, '0);
    drain(4);
    if (!m_prev_ws) slot(1, 16, '0);
    slot(0, 16, 16'hBEEF);
    slot(1, 16, 16'hCAFE);
    slot(0, 16, 16'h1357);
    slot(1, 9, 16'h2468);
    drain(0);
    reset = 0;
    #1;
    check_zero("async_reset");
    m_locked = 0; m_hv = 0; m_prev_ws = 0; p_len = 0;
    repeat (2) @(negedge serial_clk);
    reset = 1;
    slot(1, 16, 16'h0000);
    slot(0, 16, 16'h0F0F);
    slot(1, 16, 16'hF0F0);
    slot(0, 16, 16'h0001);
    slot(1, 40, 16'h0000);
    drain(8);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
I2S receiver. It deserialises a 2-channel, MSB-first I2S stream from the audio ADC into parallel left/right samples. It runs in the serial bit-clock domain as the slave of the locally generated serial_clk and word_select. It feeds the processing chain with one left/right sample pair per frame plus a valid strobe, and reports framing errors.

Parameters:
DATA_WIDTH, 16, bits per captured sample (MSB-first, left-justified in slot)
SLOT_BITS, 16, serial_clk periods per channel slot; must be >= DATA_WIDTH

Ports:
serial_clk  input  1  bit clock; all logic on posedge
reset  input  1  asynchronous, active-low reset
word_select  input  1  I2S WS; 0 = left slot, 1 = right slot; synchronous to serial_clk
sound_bit_in  input  1  I2S serial data, sampled on posedge serial_clk
left_out  output  DATA_WIDTH  last complete left sample
right_out  output  DATA_WIDTH  last complete right sample
sample_valid  output  1  1-cycle pulse: left_out/right_out hold a new pair
frame_error  output  1  1-cycle pulse on framing violation
locked  output  1  1 while in RECEIVING state

Behaviour:
- Single clock serial_clk; reset asynchronous active-low. Inputs are sampled directly, with no synchroniser.
- Reset values: left_out = 0, right_out = 0, sample_valid = 0, frame_error = 0, locked = 0, ws_d = 0, bit_cnt = 0, shift register = 0, state = SYNC_WAIT.
- ws_d holds word_select sampled on the previous edge. A WS edge is word_select != ws_d; falling = 1->0, rising = 0->1.
- I2S timing: the bit sampled on the edge where the new WS is first seen is the LSB of the previous word. The MSB of the new word is the next bit.
- bit_cnt counts bits sampled since the last WS-edge cycle; the edge cycle itself sets bit_cnt <= 0.
- Shift: shift_reg <= {shift_reg[DATA_WIDTH-2:0], sound_bit_in} only while bit_cnt < DATA_WIDTH. This includes the edge cycle. Slot bits beyond DATA_WIDTH are ignored.
- SYNC_WAIT:
  - Ignore data; locked = 0.
  - A rising edge is ignored.
  - A falling edge sets bit_cnt <= 0 and moves to RECEIVING. No word is emitted, because the preceding right word is partial.
- RECEIVING, WS-edge cycle with bit_cnt == SLOT_BITS-1 (a good word):
  - Completed word = shifted value including this cycle's bit.
  - Rising edge (left word complete): hold it in an internal left_hold register.
  - Falling edge (right word complete): right_out <= word, left_out <= left_hold, sample_valid = 1 for one cycle.
  - Outputs are registered, so they change on the same posedge as the LSB sample and are visible the following cycle.
- RECEIVING, WS-edge cycle with bit_cnt != SLOT_BITS-1 (early edge):
  - Discard the word and pulse frame_error.
  - Stay in RECEIVING, realigned to this edge (bit_cnt <= 0).
  - If the early edge is falling, left_hold is invalidated, so the next right completion does not assert sample_valid until a new left word has completed.
- RECEIVING, no WS edge while bit_cnt == SLOT_BITS-1 (overrun / missing WS):
  - Pulse frame_error and go to SYNC_WAIT.
  - Clear left_hold valid; left_out/right_out retain their values.
- frame_error and sample_valid are never asserted in the same cycle.
- A reset assertion mid-frame returns every register to its reset value immediately, asynchronously.
- bit_cnt width = clog2(SLOT_BITS); it never wraps in RECEIVING (overrun is caught first).

Optional Feature:
I2S_RX_MONO_EN
- Defined:
  - Adds output mono_out (DATA_WIDTH).
  - mono_out = (signed left + signed right) >>> 1, computed in a DATA_WIDTH+1 sum with arithmetic shift.
  - Registered alongside left_out/right_out, so it updates on the sample_valid cycle; reset value 0.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, WS low for 16 bits, then standard frames L = 0xA5C3, R = 0x1234 -> first falling edge locks (locked = 1). After the next falling edge: sample_valid 1 cycle, left_out = 0xA5C3, right_out = 0x1234.
- Three consecutive frames (0x0001/0x8000, 0xFFFF/0x0000, 0x7FFF/0x8001) -> exactly one sample_valid per frame, 32 cycles apart, correct values each time.
- Rising WS edge after only 10 left bits -> frame_error pulse, no sample_valid for that frame. The next full frame 0x1111/0x2222 is output correctly.
- WS held low for 20 bits while locked -> frame_error at bit_cnt == 15 without edge, locked = 0. Recovery: valid output after a new falling edge plus one full frame.
- Reset asserted at bit 8 of a right word -> all outputs 0 immediately. After release there is no sample_valid until a falling edge plus a full frame.
- With I2S_RX_MONO_EN: L = 0x7FFF, R = 0x7FFF -> mono_out = 0x7FFF. L = 0x8000, R = 0x7FFF -> mono_out = 0xFFFF. L = 0x0004, R = 0x0002 -> mono_out = 0x0003.
